// File: rtl/alu_serial_adder_pkg.sv
// Shared types and defaults for the digit-serial ALU adder stage.
// Operation encodings are shared with the upstream operand extender.
package alu_serial_adder_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DIGIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_INC  = 2'b10,
        OP_PASS = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_digit_add.sv
// Combinational DIGIT-wide adder slice with carry-in and carry-out.
module alu_digit_add
    import alu_serial_adder_pkg::*;
#(
    parameter int unsigned DIGIT = DIGIT_DEF
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             ci_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             co_o
);

    localparam int unsigned SW = DIGIT + 1;

    assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + SW'(ci_i);

endmodule

// File: rtl/alu_serial_adder.sv
// Digit-serial adder: captures operands, adds one DIGIT slice per clock,
// then presents result and C/V/N/Z flags through a valid/ready handshake.
module alu_serial_adder
    import alu_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  result_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              flag_c_q;
    logic              flag_v_q;
    logic              flag_n_q;
    logic              flag_z_q;

    logic [BW-1:0]     lsb;
    logic [DIGIT-1:0]  dsum;
    logic              dco;
    logic [WIDTH-1:0]  res_d;
    logic              last_dig;

    assign lsb      = BW'(32'(idx_q) * DIGIT);
    assign last_dig = (idx_q == IDXW'(NDIG - 1));

    alu_digit_add #(.DIGIT(DIGIT)) u_digit_add (
        .a_i   (a_q[lsb +: DIGIT]),
        .b_i   (b_q[lsb +: DIGIT]),
        .ci_i  (carry_q),
        .sum_o (dsum),
        .co_o  (dco)
    );

    // Result with the current digit merged in; complete on the last digit.
    always_comb begin
        res_d              = result_q;
        res_d[lsb +: DIGIT] = dsum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= opa;
                        b_q        <= opb;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q <= res_d;
                    carry_q  <= dco;
                    idx_q    <= idx_q + IDXW'(1);
                    if (last_dig) begin
                        flag_c_q    <= dco;
                        flag_v_q    <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (res_d[WIDTH-1] != a_q[WIDTH-1]);
                        flag_n_q    <= res_d[WIDTH-1];
                        flag_z_q    <= (res_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Handshake edge only retires the result; no capture here.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_alu_serial_adder.sv
// Self-checking bench for alu_serial_adder: default DIGIT=4 instance against a
// transaction-level model, plus DIGIT=1/2/8 instances for latency and results.
module tb_alu_serial_adder;
    import alu_serial_adder_pkg::*;

    localparam int unsigned NDIG_M = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] opa, opb, result;
    logic       cin, fc, fv, fn, fz;

    logic       sw_iv [3];
    logic       sw_ir [3];
    logic       sw_ov [3];
    logic       sw_or [3];
    logic [7:0] sw_res [3];
    logic       sw_c [3];
    logic       sw_v [3];
    logic       sw_n [3];
    logic       sw_z [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_serial_adder #(.WIDTH(8), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opa(opa), .opb(opb), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flag_c(fc), .flag_v(fv),
        .flag_n(fn), .flag_z(fz)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sw
        alu_serial_adder #(.WIDTH(8), .DIGIT((g == 0) ? 1 : ((g == 1) ? 2 : 8))) u_sw (
            .clk(clk), .rst(rst), .in_valid(sw_iv[g]), .in_ready(sw_ir[g]),
            .opa(opa), .opb(opb), .cin(cin), .out_valid(sw_ov[g]),
            .out_ready(sw_or[g]), .result(sw_res[g]), .flag_c(sw_c[g]),
            .flag_v(sw_v[g]), .flag_n(sw_n[g]), .flag_z(sw_z[g])
        );
    end

    // Reference: {C, V, N, Z, result} straight from the arithmetic definition.
    function automatic logic [11:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                            input logic c);
        logic [8:0] s;
        logic [7:0] r;
        s = {1'b0, a} + {1'b0, b} + 9'(c);
        r = s[7:0];
        return {s[8], (a[7] == b[7]) && (r[7] != a[7]), r[7], (r == 8'h00), r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the default instance.
    bit         m_busy  = 1'b0;
    bit         m_valid = 1'b0;
    bit         m_ready = 1'b1;
    bit         m_clr   = 1'b1;
    int         m_cnt   = 0;
    logic [11:0] m_exp  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_valid = 1'b0; m_ready = 1'b1; m_clr = 1'b1; m_cnt = 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0; m_ready = 1'b1;
            end
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 1'b0; m_valid = 1'b1;
            end
        end else if (in_valid) begin
            m_exp = ref_add(opa, opb, cin);
            m_busy = 1'b1; m_cnt = NDIG_M; m_ready = 1'b0; m_clr = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("in_ready", 32'(in_ready), 32'(m_ready));
        if (m_valid) check("result_flags", 32'({fc, fv, fn, fz, result}), 32'(m_exp));
        if (m_clr) check("cleared", 32'({fc, fv, fn, fz, result}), 32'(0));
    end

    function automatic logic get_ov(input int g);
        return (g == 3) ? out_valid : sw_ov[g];
    endfunction

    function automatic logic get_ir(input int g);
        return (g == 3) ? in_ready : sw_ir[g];
    endfunction

    function automatic logic [11:0] get_obs(input int g);
        if (g == 3) return {fc, fv, fn, fz, result};
        return {sw_c[g], sw_v[g], sw_n[g], sw_z[g], sw_res[g]};
    endfunction

    task automatic set_iv(input int g, input logic v);
        if (g == 3) in_valid = v; else sw_iv[g] = v;
    endtask

    task automatic set_or(input int g, input logic v);
        if (g == 3) out_ready = v; else sw_or[g] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, return observed outputs and accept-to-valid latency.
    task automatic run_op(input int g, input logic [7:0] a, input logic [7:0] b,
                          input logic c, output logic [11:0] obs, output int lat);
        int t = 0;
        while (!get_ir(g) && t < 100) begin tick(); t++; end
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL ready_timeout inst=%0d actual=0 required=1", g);
        end
        opa = a; opb = b; cin = c;
        set_iv(g, 1'b1);
        tick();
        set_iv(g, 1'b0);
        lat = 0;
        while (!get_ov(g) && lat < 100) begin tick(); lat++; end
        if (lat >= 100) begin
            checks++; errors++;
            $display("FAIL valid_timeout inst=%0d actual=0 required=1", g);
        end
        obs = get_obs(g);
    endtask

    task automatic consume(input int g);
        set_or(g, 1'b1);
        tick();
        set_or(g, 1'b0);
        check("consume_in_ready", 32'(get_ir(g)), 32'(1));
        check("consume_out_valid", 32'(get_ov(g)), 32'(0));
    endtask

    task automatic gen_op(output logic [7:0] a, output logic [7:0] b, output logic c);
        logic [7:0] bb;
        logic [1:0] sel;
        sel = 2'($urandom_range(0, 3));
        a   = 8'($urandom);
        bb  = 8'($urandom);
        case (alu_op_e'(sel))
            OP_ADD:  begin b = bb;    c = 1'b0; end
            OP_SUB:  begin b = ~bb;   c = 1'b1; end
            OP_INC:  begin b = 8'h00; c = 1'b1; end
            default: begin b = 8'h00; c = 1'b0; end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [11:0] obs;
        logic [11:0] held;
        int          lat;
        logic [7:0]  ra, rb;
        logic        rc;
        int          sw_lat [3] = '{8, 4, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opa = '0; opb = '0; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin sw_iv[i] = 1'b0; sw_or[i] = 1'b0; end
        repeat (2) tick();
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'(1));
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_outputs", 32'({fc, fv, fn, fz, result}), 32'(0));

        run_op(3, 8'h7F, 8'h01, 1'b0, obs, lat);
        check("add_latency", 32'(lat), 32'(2));
        check("add_7f_01", 32'(obs), 32'(12'h680));
        consume(3);

        run_op(3, 8'h05, 8'hF8, 1'b1, obs, lat);
        check("sub_5_7", 32'(obs), 32'(12'h2FE));
        consume(3);

        run_op(3, 8'hFF, 8'h01, 1'b0, obs, lat);
        check("wrap_ff_01", 32'(obs), 32'(12'h900));
        consume(3);

        // Backpressure: outputs hold while new operands are offered.
        run_op(3, 8'h12, 8'h34, 1'b0, obs, lat);
        check("bp_first", 32'(obs), 32'(12'h046));
        held = obs;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            opa = 8'($urandom); opb = 8'($urandom); cin = 1'($urandom);
            tick();
            check("bp_hold", 32'({fc, fv, fn, fz, result}), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'(0));
        end
        in_valid = 1'b1;
        consume(3);
        in_valid = 1'b0;

        // Reset during the first RUN cycle aborts the operation.
        opa = 8'h55; opb = 8'h66; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_outputs", 32'({out_valid, fc, fv, fn, fz, result}), 32'(0));
        check("abort_in_ready", 32'(in_ready), 32'(1));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_valid", 32'(out_valid), 32'(0));
        end
        run_op(3, 8'h10, 8'h20, 1'b0, obs, lat);
        check("post_abort_latency", 32'(lat), 32'(2));
        check("post_abort_10_20", 32'(obs), 32'(12'h030));
        consume(3);

        // Random traffic on the default instance, checked by the model each cycle.
        for (int i = 0; i < 400; i++) begin
            gen_op(ra, rb, rc);
            opa = ra; opb = rb; cin = rc;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;

        // Digit-width sweep.
        for (int g = 0; g < 3; g++) begin
            run_op(g, 8'h80, 8'h80, 1'b0, obs, lat);
            check("sweep_latency", 32'(lat), 32'(sw_lat[g]));
            check("sweep_80_80", 32'(obs), 32'(12'hD00));
            consume(g);
            for (int k = 0; k < 4; k++) begin
                gen_op(ra, rb, rc);
                run_op(g, ra, rb, rc, obs, lat);
                check("sweep_rand_latency", 32'(lat), 32'(sw_lat[g]));
                check("sweep_rand", 32'(obs), 32'(ref_add(ra, rb, rc)));
                consume(g);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
